// File: rtl/grid_therm_decoder_if.sv
// grid_therm_decoder_if
// Bundles the thermometer-word input handshake and the decoded result /
// statistics outputs of grid_therm_decoder.
//   in_valid, therm           : word from the prefix-AND grid (N bits, bit 0 fills first)
//   out_valid, count,
//   bubble_err                : decoded result, 2 clocks after the input
//   err_cnt, full_run         : saturating statistics
//   err_clr, err_sticky       : only with GRID_THERM_DECODER_STICKY_EN defined
// Modports: master = producer/consumer side (testbench, link logic),
//           slave  = the decoder itself.
interface grid_therm_decoder_if #(
  parameter int N     = 3,
  parameter int CW    = 2,
  parameter int RUN_W = 4
);
  logic             in_valid;
  logic [N-1:0]     therm;
  logic             out_valid;
  logic [CW-1:0]    count;
  logic             bubble_err;
  logic [7:0]       err_cnt;
  logic [RUN_W-1:0] full_run;
`ifdef GRID_THERM_DECODER_STICKY_EN
  logic             err_clr;
  logic             err_sticky;

  modport master (
    output in_valid, therm, err_clr,
    input  out_valid, count, bubble_err, err_cnt, full_run, err_sticky
  );
  modport slave (
    input  in_valid, therm, err_clr,
    output out_valid, count, bubble_err, err_cnt, full_run, err_sticky
  );
`else
  modport master (
    output in_valid, therm,
    input  out_valid, count, bubble_err, err_cnt, full_run
  );
  modport slave (
    input  in_valid, therm,
    output out_valid, count, bubble_err, err_cnt, full_run
  );
`endif
endinterface

// File: rtl/grid_therm_decoder.sv
// grid_therm_decoder
// Receive-side decoder for the interlink prefix-AND grid. Registers the
// incoming N-bit thermometer word, checks that it is a legal LSB-filled code,
// converts it to a binary fill count and keeps error / full-run statistics.
// Latency is 2 clocks from in_valid to out_valid, one word per clock.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : grid_therm_decoder_if.slave (in_valid, therm, out_valid, count,
//          bubble_err, err_cnt, full_run; err_clr/err_sticky when enabled)
// Optional feature: define GRID_THERM_DECODER_STICKY_EN to add the err_clr
// input and the err_sticky output (sticky bubble flag, set wins over clear).
module grid_therm_decoder #(
  parameter int N     = 3,
  parameter int CW    = 2,
  parameter int RUN_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  grid_therm_decoder_if.slave bus
);

  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [7:0]       ERR_MAX = 8'hFF;

  // Stage 1: raw word capture
  logic             s1_valid_reg;
  logic [N-1:0]     s1_therm_reg;

  // Stage 2: decoded result and statistics
  logic             out_valid_reg;
  logic [CW-1:0]    count_reg;
  logic             bubble_reg;
  logic [7:0]       err_cnt_reg;
  logic [RUN_W-1:0] full_run_reg;

  // Decode of the stage-1 word
  logic [N-1:0]     prefix;
  logic [CW-1:0]    dec_count;
  logic             dec_bubble;
  logic             dec_all_ones;

  // prefix[i] is 1 only while every bit from 0 up to i is set, so prefix is
  // the legal thermometer code of the leading run of ones. The word is legal
  // exactly when it equals its own prefix.
  assign prefix[0] = s1_therm_reg[0];
  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_prefix
      assign prefix[gi] = prefix[gi-1] & s1_therm_reg[gi];
    end
  endgenerate

  always_comb begin
    dec_count = '0;
    for (int i = 0; i < N; i++) begin
      dec_count = dec_count + CW'(prefix[i]);
    end
  end

  assign dec_bubble   = (prefix != s1_therm_reg);
  assign dec_all_ones = prefix[N-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_therm_reg <= '0;
    end else begin
      s1_valid_reg <= bus.in_valid;
      s1_therm_reg <= bus.therm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      count_reg     <= '0;
      bubble_reg    <= 1'b0;
      err_cnt_reg   <= '0;
      full_run_reg  <= '0;
    end else begin
      out_valid_reg <= s1_valid_reg;
      // count/bubble_err hold their last value across idle cycles
      if (s1_valid_reg) begin
        count_reg  <= dec_count;
        bubble_reg <= dec_bubble;
        if (dec_bubble && (err_cnt_reg != ERR_MAX)) begin
          err_cnt_reg <= err_cnt_reg + 8'd1;
        end
        if (!dec_all_ones) begin
          full_run_reg <= '0;
        end else if (full_run_reg != RUN_MAX) begin
          full_run_reg <= full_run_reg + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.count      = count_reg;
  assign bus.bubble_err = bubble_reg;
  assign bus.err_cnt    = err_cnt_reg;
  assign bus.full_run   = full_run_reg;

`ifdef GRID_THERM_DECODER_STICKY_EN
  logic sticky_reg;

  // Set is checked first so a bubble presented on the same edge as err_clr
  // leaves the flag asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_reg <= 1'b0;
    end else if (s1_valid_reg && dec_bubble) begin
      sticky_reg <= 1'b1;
    end else if (bus.err_clr) begin
      sticky_reg <= 1'b0;
    end
  end

  assign bus.err_sticky = sticky_reg;
`endif

endmodule

// File: tb/tb_grid_therm_decoder.sv
module tb_grid_therm_decoder;

  localparam int N     = 3;
  localparam int CW    = 2;
  localparam int RUN_W = 4;
  localparam int NV    = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  grid_therm_decoder_if #(.N(N), .CW(CW), .RUN_W(RUN_W)) bus ();

  grid_therm_decoder #(.N(N), .CW(CW), .RUN_W(RUN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N-1:0] therm;
    int           exp_count;
    int           exp_bubble;
    int           exp_err_cnt;
    int           exp_full_run;
  } vec_t;

  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] t, input logic v);
    bus.therm    = t;
    bus.in_valid = v;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // therm, count, bubble, err_cnt, full_run (cumulative from reset)
    vecs[0] = '{3'b000, 0, 0, 0, 0};
    vecs[1] = '{3'b001, 1, 0, 0, 0};
    vecs[2] = '{3'b011, 2, 0, 0, 0};
    vecs[3] = '{3'b111, 3, 0, 0, 1};
    vecs[4] = '{3'b101, 1, 1, 1, 0};
    vecs[5] = '{3'b110, 0, 1, 2, 0};
    vecs[6] = '{3'b010, 0, 1, 3, 0};
    vecs[7] = '{3'b111, 3, 0, 3, 1};
    vecs[8] = '{3'b111, 3, 0, 3, 2};
    vecs[9] = '{3'b000, 0, 0, 3, 0};

    bus.in_valid = 1'b0;
    bus.therm    = '0;
`ifdef GRID_THERM_DECODER_STICKY_EN
    bus.err_clr  = 1'b0;
`endif

    // ---------------- reset state ----------------
    do_reset();
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset count", int'(bus.count), 0);
    chk("reset err_cnt", int'(bus.err_cnt), 0);

    // ---------------- table sweep, streamed back-to-back ----------------
    for (int i = 0; i <= NV + 1; i++) begin
      if (i < NV) send(vecs[i].therm, 1'b1);
      else        send('0, 1'b0);
      if (i >= 1 && i <= NV) begin
        $display("vec %0d therm=%b count=%0d bubble=%0d err_cnt=%0d full_run=%0d",
                 i-1, vecs[i-1].therm, bus.count, bus.bubble_err, bus.err_cnt, bus.full_run);
        chk($sformatf("vec%0d out_valid", i-1), int'(bus.out_valid), 1);
        chk($sformatf("vec%0d count", i-1), int'(bus.count), vecs[i-1].exp_count);
        chk($sformatf("vec%0d bubble_err", i-1), int'(bus.bubble_err), vecs[i-1].exp_bubble);
        chk($sformatf("vec%0d err_cnt", i-1), int'(bus.err_cnt), vecs[i-1].exp_err_cnt);
        chk($sformatf("vec%0d full_run", i-1), int'(bus.full_run), vecs[i-1].exp_full_run);
      end
    end
    $display("idle after sweep: out_valid=%0d count=%0d", bus.out_valid, bus.count);
    chk("idle out_valid", int'(bus.out_valid), 0);
    chk("idle count hold", int'(bus.count), 0);
    chk("idle err_cnt hold", int'(bus.err_cnt), 3);

    // ---------------- reset mid-stream ----------------
    send(3'b111, 1'b1);
    send(3'b111, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset: out_valid=%0d count=%0d err_cnt=%0d full_run=%0d",
             bus.out_valid, bus.count, bus.err_cnt, bus.full_run);
    chk("async rst out_valid", int'(bus.out_valid), 0);
    chk("async rst count", int'(bus.count), 0);
    chk("async rst bubble_err", int'(bus.bubble_err), 0);
    chk("async rst err_cnt", int'(bus.err_cnt), 0);
    chk("async rst full_run", int'(bus.full_run), 0);
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      $display("post-reset cycle %0d: out_valid=%0d", i, bus.out_valid);
      chk($sformatf("post rst stale%0d", i), int'(bus.out_valid), 0);
    end

    // ---------------- full_run with idle gap, saturation, clear ----------------
    do_reset();
    for (int i = 0; i < 3; i++) send(3'b111, 1'b1);
    send('0, 1'b0);
    send('0, 1'b0);
    $display("full_run gap: out_valid=%0d full_run=%0d", bus.out_valid, bus.full_run);
    chk("full_run gap out_valid", int'(bus.out_valid), 0);
    chk("full_run gap hold", int'(bus.full_run), 3);
    for (int i = 0; i < 17; i++) send(3'b111, 1'b1);
    send('0, 1'b0);
    send('0, 1'b0);
    $display("full_run saturated: full_run=%0d", bus.full_run);
    chk("full_run saturate", int'(bus.full_run), 15);
    send(3'b011, 1'b1);
    send('0, 1'b0);
    send('0, 1'b0);
    $display("full_run after 011: full_run=%0d count=%0d", bus.full_run, bus.count);
    chk("full_run clear", int'(bus.full_run), 0);
    chk("count after 011", int'(bus.count), 2);

    // ---------------- err_cnt saturation ----------------
    do_reset();
    for (int i = 0; i < 254; i++) send(3'b101, 1'b1);
    send('0, 1'b0);
    send('0, 1'b0);
    $display("err_cnt after 254 bubbles: %0d", bus.err_cnt);
    chk("err_cnt 254", int'(bus.err_cnt), 254);
    for (int i = 0; i < 46; i++) send(3'b101, 1'b1);
    send('0, 1'b0);
    send('0, 1'b0);
    $display("err_cnt after 300 bubbles: %0d", bus.err_cnt);
    chk("err_cnt saturate", int'(bus.err_cnt), 255);
    chk("bubble count 101", int'(bus.count), 1);

`ifdef GRID_THERM_DECODER_STICKY_EN
    // ---------------- sticky flag ----------------
    do_reset();
    chk("sticky reset", int'(bus.err_sticky), 0);
    send(3'b101, 1'b1);
    send(3'b110, 1'b1);              // edge presents the first bubble
    chk("sticky set", int'(bus.err_sticky), 1);
    bus.err_clr = 1'b1;
    send('0, 1'b0);                  // edge presents the second bubble with clear
    $display("sticky set+clr: sticky=%0d err_cnt=%0d", bus.err_sticky, bus.err_cnt);
    chk("sticky set wins", int'(bus.err_sticky), 1);
    chk("sticky err_cnt 2", int'(bus.err_cnt), 2);
    send('0, 1'b0);                  // clear with no error present
    bus.err_clr = 1'b0;
    $display("sticky clr: sticky=%0d err_cnt=%0d", bus.err_sticky, bus.err_cnt);
    chk("sticky cleared", int'(bus.err_sticky), 0);
    chk("sticky err_cnt kept", int'(bus.err_cnt), 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/grid_therm_decoder.md
Name: grid_therm_decoder

Overview:
Receive-side counterpart of the interlink prefix-AND grid. It accepts the N-bit thermometer word that the grid emits, registers it, and checks that it is a legal LSB-filled thermometer code. It then converts the word to a binary fill count and keeps error and run statistics. It sits at the consuming end of the grid link and feeds the binary count to downstream control logic.

Parameters:
- N, 3, thermometer word width; legal range 2..16.
- CW, 2, binary count width; must satisfy 2^CW >= N+1.
- RUN_W, 4, width of the consecutive-full-word run counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  qualifies therm this cycle.
- therm  input  N  thermometer word, bit 0 fills first.
- out_valid  output  1  qualifies count/bubble_err.
- count  output  CW  binary fill count of the decoded word.
- bubble_err  output  1  decoded word was not a legal thermometer code.
- err_cnt  output  8  saturating count of bubble errors.
- full_run  output  RUN_W  saturating count of consecutive valid all-ones words.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-high on rst. While rst=1, all registers clear immediately and stay cleared. Outputs then read out_valid=0, count=0, bubble_err=0, err_cnt=0, full_run=0. Words in flight when rst asserts are discarded and never appear on the outputs.
- Pipeline, stage 1: on each rising edge, therm and in_valid are registered unconditionally.
- Pipeline, stage 2: on the next rising edge, the stage-1 word is decoded into count, bubble_err and out_valid.
- Latency and throughput: fixed latency of 2 clocks, in_valid to out_valid. One word per clock; there is no backpressure.
- Legal codes: for N=3 these are 000, 001, 011 and 111. In general a legal code is k ones in bits [k-1:0] with zeros above, for k = 0..N.
- Legal word: count = k and bubble_err = 0.
- Illegal word: bubble_err = 1, and count = the length of the contiguous run of ones starting at bit 0. Examples: 101 gives count 1; 110 gives count 0.
- Invalid stage-1 word: when the stage-1 in_valid = 0, then out_valid = 0, count and bubble_err hold their previous values, and the statistics hold.
- err_cnt: increments by 1 on each out_valid word with bubble_err=1. It saturates at 255 and never wraps.
- full_run, increment: increments on each valid word that is all ones. It saturates at 2^RUN_W - 1.
- full_run, clear: clears to 0 on any valid word that is not all ones, including illegal words.
- full_run, idle: holds its value on invalid cycles.
- Statistics timing: err_cnt and full_run update on the same edge that presents the word on out_valid.

Optional Feature:
- Macro: GRID_THERM_DECODER_STICKY_EN.
- Defined: adds input err_clr (1 bit) and output err_sticky (1 bit).
- err_sticky reset value is 0.
- err_sticky sets on the edge that presents any out_valid word with bubble_err=1.
- err_sticky clears on an edge where err_clr=1.
- If a set and err_clr=1 fall on the same edge, err_sticky ends at 1 (set wins).
- err_clr has no effect on err_cnt.
- Not defined: neither port exists and the rest of the behaviour is unchanged.

Test Plan:
- Reset: assert rst mid-stream while in_valid=1 with therm=111. Required: all outputs read 0 immediately (before the next edge). After release, no stale out_valid appears.
- Legal sweep: N=3, apply therm 000, 001, 011, 111 back-to-back with in_valid=1. Required: 2 clocks later, count = 0, 1, 2, 3 on consecutive cycles, bubble_err=0 and err_cnt=0.
- Bubbles: apply 101, then 110, then 010. Required: count = 1, 0, 0; bubble_err=1 on each word; err_cnt ends at 3.
- full_run: apply 111 twenty times, then 011. Required: full_run = 15 while saturated with RUN_W=4, then 0 after the 011 word. An idle gap with in_valid=0 inside the run holds the value.
- err_cnt saturation: apply 300 consecutive 101 words. Required: err_cnt reaches 255 and stays at 255.
- Sticky feature (macro defined): apply a bubble word, then err_clr=1 on the same edge a second bubble word is presented. Required: err_sticky stays 1. A later err_clr with no error present clears it to 0, and err_cnt is unaffected.
